div16u8_seq: RTL

Sequential unsigned 16÷8 divider, the inverse operation of the library's 8×8 unsigned multipliers. It sits next to the mul8u family in the characterisation harness and recovers a 16-bit dividend into an 8-bit quotient plus remainder. Operands are accepted and results returned on valid/ready handshakes. One quotient bit is resolved per cycle with a restoring algorithm, and the block flags divide-by-zero and quotient overflow.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_step.sv | 33 +++
 rtl/div16u8_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared declarations for the sequential unsigned divider (div16u8_seq).
//   div_state_t : controller states (IDLE / CALC / DONE)
//   DIV_W       : default divisor / quotient / remainder width
//   div_trunc() : approximate-build dividend truncation (zeroes the low DIV_W/2
//                 bits, matching the dropped low product bits of the
//                 approximate multipliers this divider is paired with)
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic [2*DIV_W-1:0] div_trunc(input logic [2*DIV_W-1:0] dividend);
    logic [2*DIV_W-1:0] d;
    d = dividend;
    d[DIV_W/2-1:0] = '0;
    return d;
  endfunction

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem      in  W   partial remainder (always < divisor on entry)
//   in_bit   in  1   next dividend bit, MSB first
//   divisor  in  W   divisor
//   rem_next out W   partial remainder after this step
//   q_bit    out 1   resolved quotient bit
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] rem,
  input  logic         in_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] trial;
  logic [W:0] diff;

  assign trial = {rem, in_bit};
  assign diff  = trial - {1'b0, divisor};
  assign q_bit = (trial >= {1'b0, divisor});

  // Because rem < divisor, trial < 2*divisor, so trial - divisor < divisor and
  // the subtracted value always fits back into W bits.
  assign rem_next = q_bit ? diff[W-1:0] : trial[W-1:0];

endmodule : div_step

// File: rtl/div16u8_seq.sv
// -----------------------------------------------------------------------------
// div16u8_seq
// Sequential unsigned 2W / W restoring divider with valid/ready handshakes.
// One quotient bit is resolved per CALC cycle; divide-by-zero and quotient
// overflow are detected at accept time and reported with an all-ones quotient
// and a zero remainder.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous, active-high reset
//   in_valid   in   1    operand pair valid
//   in_ready   out  1    ready for operands (IDLE only, from state alone)
//   dividend   in   2W   unsigned dividend
//   divisor    in   W    unsigned divisor
//   out_valid  out  1    result valid (DONE only, from state alone)
//   out_ready  in   1    consumer accepts result
//   quotient   out  W    unsigned quotient
//   remainder  out  W    unsigned remainder
//   dz         out  1    divide-by-zero flag
//   ovf        out  1    quotient-overflow flag
//
// Build option:
//   DIV16U8_SEQ_APPROX_EN  when defined, the low W/2 dividend bits are forced
//                          to zero before the checks and the iterations.
//                          Latency and handshake are unchanged.
// -----------------------------------------------------------------------------
module div16u8_seq
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           dz,
  output logic           ovf
);

  localparam int CW = $clog2(W);

  div_state_t state, state_next;

  // Working registers of the iteration.
  logic [W-1:0]  dvsr_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  shreg_q;
  logic [W-1:0]  quot_q;
  logic [CW-1:0] cnt_q;

  logic [2*W-1:0] dvd_eff;
  logic           in_dz;
  logic           in_ovf;
  logic           calc_last;
  logic [W-1:0]   step_rem;
  logic           step_q;

  // ---------------------------------------------------------------------------
  // Effective dividend
  // ---------------------------------------------------------------------------
`ifdef DIV16U8_SEQ_APPROX_EN
  generate
    if (W == DIV_W) begin : g_trunc_pkg
      assign dvd_eff = div_trunc(dividend);
    end else begin : g_trunc_inline
      assign dvd_eff = {dividend[2*W-1:W/2], {(W/2){1'b0}}};
    end
  endgenerate
`else
  assign dvd_eff = dividend;
`endif

  // The quotient fits in W bits only when the high half is below the divisor.
  assign in_dz     = (divisor == '0);
  assign in_ovf    = !in_dz && (dvd_eff[2*W-1:W] >= divisor);
  assign calc_last = (cnt_q == CW'(W - 1));

  // ---------------------------------------------------------------------------
  // Single shared restoring step, fed with the dividend bits MSB first
  // ---------------------------------------------------------------------------
  div_step #(.W(W)) u_step (
    .rem      (rem_q),
    .in_bit   (shreg_q[W-1]),
    .divisor  (dvsr_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of the order the processes are evaluated.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of latches
  // on any path that does not explicitly assign state_next.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid)  state_next = (in_dz || in_ovf) ? DONE : CALC;
      CALC: if (calc_last) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (state only, no combinational handshake paths)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dvsr_q    <= '0;
      rem_q     <= '0;
      shreg_q   <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dvsr_q  <= divisor;
            rem_q   <= dvd_eff[2*W-1:W];
            shreg_q <= dvd_eff[W-1:0];
            quot_q  <= '0;
            cnt_q   <= '0;
            if (in_dz || in_ovf) begin
              quotient  <= '1;
              remainder <= '0;
              dz        <= in_dz;
              ovf       <= in_ovf;
            end
          end
        end

        CALC: begin
          rem_q   <= step_rem;
          shreg_q <= {shreg_q[W-2:0], 1'b0};
          quot_q  <= {quot_q[W-2:0], step_q};
          cnt_q   <= cnt_q + CW'(1);
          // The final step writes straight into the result registers so the
          // result is presented the cycle DONE is entered.
          if (calc_last) begin
            quotient  <= {quot_q[W-2:0], step_q};
            remainder <= step_rem;
          end
        end

        DONE: begin
          if (out_ready) begin
            dz  <= 1'b0;
            ovf <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

endmodule : div16u8_seq
